// File: rtl/rtcomp_mc.sv
// rtl/rtcomp_mc.sv - routing-computation stage with multicast fan-out for a mesh router input port
//
// Accepts one decoded head flit per handshake. A unicast head produces one route
// record. A multicast head's destination bitmap is split by output port, and the
// non-empty subsets are issued one per cycle in the order Local, East, West,
// North, South.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid / in_ready        head handshake
//   in_mc                      1 = multicast head, 0 = unicast head
//   in_dst_x, in_dst_y         unicast destination coordinates
//   in_mdst                    multicast destination bitmap (node n = y*NX + x)
//   in_vch                     input virtual channel of the head
//   out_valid / out_ready      route record handshake
//   out_port                   one-hot {S,N,W,E,L}
//   out_ovch                   output VC, taken from the head
//   out_mask                   destinations served through out_port
//   out_last                   final record of the head
module rtcomp_mc #(
  parameter int MY_XPOS  = 0,
  parameter int MY_YPOS  = 0,
  parameter int NX       = 4,
  parameter int NY       = 4,
  parameter int NVCH     = 2,
  parameter int ROUTE_YX = 0,
  localparam int XW   = (NX > 1) ? $clog2(NX) : 1,
  localparam int YW   = (NY > 1) ? $clog2(NY) : 1,
  localparam int VCHW = (NVCH > 1) ? $clog2(NVCH) : 1,
  localparam int NN   = NX * NY
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mc,
  input  logic [XW-1:0]   in_dst_x,
  input  logic [YW-1:0]   in_dst_y,
  input  logic [NN-1:0]   in_mdst,
  input  logic [VCHW-1:0] in_vch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_port,
  output logic [VCHW-1:0] out_ovch,
  output logic [NN-1:0]   out_mask,
  output logic            out_last
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state, state_next;

  // Subsets not yet issued; the one currently on out_* is already removed.
  logic [4:0][NN-1:0] pending;
  logic [4:0][NN-1:0] head_sub;
  logic [4:0][NN-1:0] src;
  logic [4:0][NN-1:0] rem;
  logic [NN-1:0]      uc_mask;
  logic [2:0]         sel_idx;
  logic               found;
  logic               accept;
  logic               load;

  // Port index: 0 Local, 1 East, 2 West, 3 North, 4 South.
  function automatic logic [2:0] route_idx(input int x, input int y);
    logic [2:0] r;
    r = 3'd0;
    if (ROUTE_YX == 0) begin
      if (x > MY_XPOS)      r = 3'd1;
      else if (x < MY_XPOS) r = 3'd2;
      else if (y > MY_YPOS) r = 3'd3;
      else if (y < MY_YPOS) r = 3'd4;
    end else begin
      if (y > MY_YPOS)      r = 3'd3;
      else if (y < MY_YPOS) r = 3'd4;
      else if (x > MY_XPOS) r = 3'd1;
      else if (x < MY_XPOS) r = 3'd2;
    end
    return r;
  endfunction

  assign out_valid = (state == ISSUE);
  assign in_ready  = !out_valid || (out_ready && out_last);
  assign accept    = in_valid && in_ready;

  // A unicast destination outside the mesh yields an empty mask and is dropped
  // like an empty multicast.
  assign uc_mask = {{(NN-1){1'b0}}, 1'b1} << (int'(in_dst_y) * NX + int'(in_dst_x));

  always_comb begin
    head_sub = '0;
    if (in_mc) begin
      for (int n = 0; n < NN; n++) begin
        head_sub[route_idx(n % NX, n / NX)][n] = in_mdst[n];
      end
    end else begin
      head_sub[route_idx(int'(in_dst_x), int'(in_dst_y))] = uc_mask;
    end
  end

  // A newly accepted head always starts from its own subsets; otherwise the
  // next record comes out of the pending register.
  assign src = accept ? head_sub : pending;

  always_comb begin
    found   = 1'b0;
    sel_idx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (!found && (|src[i])) begin
        found   = 1'b1;
        sel_idx = 3'(i);
      end
    end
    rem = src;
    if (found) rem[sel_idx] = '0;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    if (accept) begin
      load       = 1'b1;
      state_next = found ? ISSUE : IDLE;
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        state_next = IDLE;
      end else begin
        load       = 1'b1;
        state_next = ISSUE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_port <= '0;
      out_ovch <= '0;
      out_mask <= '0;
      out_last <= 1'b0;
      pending  <= '0;
    end else if (load) begin
      out_port <= found ? (5'(1) << sel_idx) : 5'd0;
      out_mask <= found ? src[sel_idx] : '0;
      out_last <= ~(|rem);
      pending  <= rem;
      if (accept) out_ovch <= in_vch;
    end
  end

endmodule
